// File: rtl/moore_pkg.sv
// Shared constants and helpers for the moore_updown_n display state machine.
//   CODE_LOCK  display code shown while in the LOCK state
//   SEG_DASH   active-low segment pattern with only segment g lit
//   SEG_BLANK  active-low segment pattern with every segment off
//   cmd_e      decoded {UP, DN} command
//   map_code   permuted display code of a ring state
package moore_pkg;

  localparam logic [3:0] CODE_LOCK = 4'hF;

  // Segment vectors are indexed [0:6] = a..g, active-low.
  localparam logic [0:6] SEG_DASH  = 7'b1111110;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  // Encoding follows {UP, DN}, so a plain cast from the switch pair decodes it.
  typedef enum logic [1:0] {
    CmdHold = 2'b00,
    CmdDn   = 2'b01,
    CmdUp   = 2'b10,
    CmdLock = 2'b11
  } cmd_e;

  // (s * k + ofs) mod n in 32-bit unsigned arithmetic, so the product never truncates.
  function automatic logic [3:0] map_code(input int unsigned s, input int unsigned k,
                                          input int unsigned ofs, input int unsigned n);
    int unsigned prod;
    prod = s * k + ofs;
    return 4'(prod % n);
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Pure combinational hex digit to 7-segment decoder.
//   code_i  4-bit value to display
//   seg_o   segments a..g on bits [0:6], active-low; 0..9 and A..E as usual, F as a dash
module seg7_hex_decoder
  import moore_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [0:6] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      4'h0:    seg_o = 7'b0000001;
      4'h1:    seg_o = 7'b1001111;
      4'h2:    seg_o = 7'b0010010;
      4'h3:    seg_o = 7'b0000110;
      4'h4:    seg_o = 7'b1001100;
      4'h5:    seg_o = 7'b0100100;
      4'h6:    seg_o = 7'b0100000;
      4'h7:    seg_o = 7'b0001111;
      4'h8:    seg_o = 7'b0000000;
      4'h9:    seg_o = 7'b0000100;
      4'hA:    seg_o = 7'b0001000;
      4'hB:    seg_o = 7'b1100000;
      4'hC:    seg_o = 7'b0110001;
      4'hD:    seg_o = 7'b1000010;
      4'hE:    seg_o = 7'b0110000;
      4'hF:    seg_o = SEG_DASH;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/moore_updown_n.sv
// Parametrised Moore up/down ring counter with a LOCK state and a 7-segment readout.
// A prescaler produces a one-cycle TICK every DIV clocks; the state only moves on TICK.
//   CLOCK50  system clock
//   RESET    synchronous, active-high reset
//   UP, DN   step commands, sampled only in TICK cycles (both high = LOCK)
//   STATE    current state register (LOCK is all-ones)
//   CODE     permuted display code of STATE
//   LOCKED   high while in LOCK
//   TICK     registered prescaler terminal-count pulse
//   HEX0     segments a..g on bits [0:6], active-low
// Build option: define MOORE_SAT_EN to saturate at the ring ends instead of wrapping.
module moore_updown_n
  import moore_pkg::*;
#(
  parameter int unsigned N_STATES = 9,
  parameter int unsigned W        = 4,
  parameter int unsigned DIV      = 50000000,
  parameter int unsigned DW       = 26,
  parameter int unsigned MAP_K    = 2,
  parameter int unsigned MAP_OFS  = 0
) (
  input  logic         CLOCK50,
  input  logic         RESET,
  input  logic         UP,
  input  logic         DN,
  output logic [W-1:0] STATE,
  output logic [3:0]   CODE,
  output logic         LOCKED,
  output logic         TICK,
  output logic [0:6]   HEX0
);

`ifdef MOORE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [W-1:0]  STATE_LOCK = '1;
  localparam logic [W-1:0]  STATE_LAST = W'(N_STATES - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);

  logic [DW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic [W-1:0]  state_q, state_d;
  cmd_e          cmd;

  // Prescaler: the terminal count both wraps the counter and arms next cycle's TICK.
  always_comb begin
    tick_d  = (presc_q == DIV_LAST);
    presc_d = tick_d ? '0 : presc_q + DW'(1);
  end

  assign cmd = cmd_e'({UP, DN});

  always_comb begin
    state_d = state_q;
    if (tick_q) begin
      if (state_q == STATE_LOCK) begin
        state_d = (cmd == CmdLock) ? STATE_LOCK : '0;
      end else if (state_q > STATE_LAST) begin
        // Unused encodings recover to the start of the ring.
        state_d = '0;
      end else begin
        unique case (cmd)
          CmdHold: state_d = state_q;
          CmdUp:   state_d = (state_q == STATE_LAST) ? (SAT ? state_q : '0) : state_q + W'(1);
          CmdDn:   state_d = (state_q == '0) ? (SAT ? state_q : STATE_LAST) : state_q - W'(1);
          CmdLock: state_d = STATE_LOCK;
          default: state_d = state_q;
        endcase
      end
    end
  end

  // RESET wins over everything, including a TICK in the same cycle.
  always_ff @(posedge CLOCK50) begin
    if (RESET) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      state_q <= '0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      state_q <= state_d;
    end
  end

  // Moore outputs depend on the state register alone.
  always_comb begin
    LOCKED = (state_q == STATE_LOCK);
    CODE   = LOCKED ? CODE_LOCK : map_code(32'(state_q), MAP_K, MAP_OFS, N_STATES);
  end

  assign STATE = state_q;
  assign TICK  = tick_q;

  seg7_hex_decoder u_hex0 (
    .code_i (CODE),
    .seg_o  (HEX0)
  );

endmodule
